// File: rtl/tick_ctrl.sv
// Game-tick controller: turns the divided source square wave into single-cycle
// tick pulses, with run/pause/step control, an optional tick budget and a core handshake.
module tick_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned BUDGET_W = 16,
  parameter int unsigned OVR_W    = 8
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                tick_src,
  input  logic                cmd_run,
  input  logic                cmd_pause,
  input  logic                cmd_step,
  input  logic                budget_en,
  input  logic [BUDGET_W-1:0] budget,
  input  logic                core_done,
  output logic                tick,
  output logic                running,
  output logic                waiting,
  output logic                halted,
  output logic [CNT_W-1:0]    tick_count,
  output logic [OVR_W-1:0]    overrun
);

  typedef enum logic [1:0] {StIdle, StRun, StWait} state_e;

  state_e              state_q, state_d;
  logic                s1_q, s2_q, s3_q;
  logic                src_edge;
  logic                tick_q, tick_d;
  logic                running_q, running_d;
  logic                waiting_q, waiting_d;
  logic                halted_q, halted_d;
  logic                step_mode_q, step_mode_d;
  logic                pause_pending_q, pause_pending_d;
  logic                budgeted_q, budgeted_d;
  logic [BUDGET_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0]    tick_count_q, tick_count_d;
  logic [OVR_W-1:0]    overrun_q, overrun_d;

  // tick_src is asynchronous data: two-flop synchronizer plus a history flop for rise detect
  assign src_edge = s2_q & ~s3_q;

  always_comb begin
    state_d         = state_q;
    tick_d          = 1'b0;
    halted_d        = 1'b0;
    step_mode_d     = step_mode_q;
    pause_pending_d = pause_pending_q;
    budgeted_d      = budgeted_q;
    remaining_d     = remaining_q;
    tick_count_d    = tick_count_q;
    overrun_d       = overrun_q;

    unique case (state_q)
      StIdle: begin
        // Pause outranks step and run, so a concurrent pause swallows both
        if (cmd_pause) begin
          state_d = StIdle;
        end else if (cmd_step) begin
          tick_d      = 1'b1;
          step_mode_d = 1'b1;
          budgeted_d  = 1'b0;
          state_d     = StWait;
        end else if (cmd_run && !(budget_en && (budget == '0))) begin
          budgeted_d  = budget_en;
          remaining_d = budget;
          overrun_d   = '0;
          step_mode_d = 1'b0;
          state_d     = StRun;
        end
      end
      StRun: begin
        if (cmd_pause) begin
          state_d = StIdle;
        end else if (src_edge) begin
          tick_d  = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cmd_pause) pause_pending_d = 1'b1;
        if (core_done) begin
          if (step_mode_q || pause_pending_q || cmd_pause) begin
            step_mode_d     = 1'b0;
            pause_pending_d = 1'b0;
            state_d         = StIdle;
          end else if (budgeted_q && (remaining_q == '0)) begin
            halted_d = 1'b1;
            state_d  = StIdle;
          end else if (src_edge) begin
            tick_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end else if (src_edge && (overrun_q != '1)) begin
          overrun_d = overrun_q + OVR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (tick_d) begin
      tick_count_d = tick_count_q + CNT_W'(1);
      if (budgeted_d) remaining_d = remaining_q - BUDGET_W'(1);
    end

    // Status flags are registered, decoded from the state and mode being entered
    running_d = (state_d == StRun) || ((state_d == StWait) && !step_mode_d);
    waiting_d = (state_d == StWait);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      s1_q            <= 1'b0;
      s2_q            <= 1'b0;
      s3_q            <= 1'b0;
      tick_q          <= 1'b0;
      running_q       <= 1'b0;
      waiting_q       <= 1'b0;
      halted_q        <= 1'b0;
      step_mode_q     <= 1'b0;
      pause_pending_q <= 1'b0;
      budgeted_q      <= 1'b0;
      remaining_q     <= '0;
      tick_count_q    <= '0;
      overrun_q       <= '0;
    end else begin
      state_q         <= state_d;
      s1_q            <= tick_src;
      s2_q            <= s1_q;
      s3_q            <= s2_q;
      tick_q          <= tick_d;
      running_q       <= running_d;
      waiting_q       <= waiting_d;
      halted_q        <= halted_d;
      step_mode_q     <= step_mode_d;
      pause_pending_q <= pause_pending_d;
      budgeted_q      <= budgeted_d;
      remaining_q     <= remaining_d;
      tick_count_q    <= tick_count_d;
      overrun_q       <= overrun_d;
    end
  end

  assign tick       = tick_q;
  assign running    = running_q;
  assign waiting    = waiting_q;
  assign halted     = halted_q;
  assign tick_count = tick_count_q;
  assign overrun    = overrun_q;

endmodule
